// File: rtl/add16_seq_ctrl_pkg.sv
// add16_seq_ctrl_pkg: shared FSM encodings and nibble constants for the serial 16-bit adder.
package add16_seq_ctrl_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
   localparam int NIBBLES = 4;
   localparam logic [1:0] LAST_IDX = 2'(NIBBLES - 1);
endpackage

// File: rtl/add16_seq_ctrl_if.sv
// add16_seq_ctrl_if: request/result handshake bundle between a producer and the serial adder.
interface add16_seq_ctrl_if;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] op_a;
   logic [15:0] op_b;
   logic        sub;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] sum;
   logic        cout;
   logic        ovf;
   modport master (
      output in_valid, op_a, op_b, sub, out_ready,
      input  in_ready, out_valid, sum, cout, ovf
   );
   modport slave (
      input  in_valid, op_a, op_b, sub, out_ready,
      output in_ready, out_valid, sum, cout, ovf
   );
endinterface

// File: rtl/add16_seq_ctrl_adder4.sv
// Adder4: 4-bit ripple adder with carry in/out, reused once per nibble by the controller.
module Adder4 (
   input  logic [3:0] A,
   input  logic [3:0] B,
   input  logic       Cin,
   output logic [3:0] Z,
   output logic       Cout
);
   assign {Cout, Z} = {1'b0, A} + {1'b0, B} + {4'b0, Cin};
endmodule

// File: rtl/add16_seq_ctrl.sv
// add16_seq_ctrl: 16-bit add/subtract computed one nibble per cycle through a single Adder4,
// with valid/ready handshakes on request and result.
module add16_seq_ctrl
   import add16_seq_ctrl_pkg::*;
(
   input logic          clk,
   input logic          rst_n,
   add16_seq_ctrl_if.slave bus
);
   state_t      state_q, state_d;
   logic [15:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
   logic        c_q, c_d, cout_q, cout_d, ovf_q, ovf_d;
   logic [$clog2(NIBBLES)-1:0] idx_q, idx_d;
   logic [3:0]  z;
   logic        co;

   Adder4 u_add (
      .A   (a_q[{idx_q, 2'b00} +: 4]),
      .B   (b_q[{idx_q, 2'b00} +: 4]),
      .Cin (c_q),
      .Z   (z),
      .Cout(co)
   );

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         a_q    <= '0;
         b_q    <= '0;
         c_q    <= 1'b0;
         idx_q  <= '0;
         sum_q  <= '0;
         cout_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         a_q    <= a_d;
         b_q    <= b_d;
         c_q    <= c_d;
         idx_q  <= idx_d;
         sum_q  <= sum_d;
         cout_q <= cout_d;
         ovf_q  <= ovf_d;
      end

   // Subtraction is A + ~B + 1: the inverted B and the carry-in of 1 are captured at accept.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      c_d     = c_q;
      idx_d   = idx_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      case (state_q)
         IDLE: if (bus.in_valid) begin
            a_d     = bus.op_a;
            b_d     = bus.sub ? ~bus.op_b : bus.op_b;
            c_d     = bus.sub;
            idx_d   = '0;
            state_d = RUN;
         end
         RUN: begin
            sum_d[{idx_q, 2'b00} +: 4] = z;
            c_d   = co;
            idx_d = idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
               state_d = DONE;
               cout_d  = co;
               ovf_d   = (a_q[15] == b_q[15]) && (z[3] != a_q[15]);
            end
         end
         DONE: if (bus.out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign bus.in_ready  = rst_n && (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.sum       = sum_q;
   assign bus.cout      = cout_q;
   assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_add16_seq_ctrl.sv
// tb_add16_seq_ctrl: directed vectors with hand-computed results for the serial adder.
module tb_add16_seq_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0;
   int   n_fail = 0;

   add16_seq_ctrl_if bus ();
   add16_seq_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // Assumes the request was accepted on the previous posedge; called at the following negedge.
   task automatic wait_done(input string tag);
      int lat = 0;
      bus.in_valid = 1'b0;
      do begin
         @(negedge clk);
         lat++;
      end while (!bus.out_valid && lat < 20);
      check({tag, "_lat"}, 32'(lat), 32'd4);
   endtask

   task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic s, input logic [15:0] e_sum, input logic e_c, input logic e_v);
      @(negedge clk);
      check({tag, "_rdy"}, {31'd0, bus.in_ready}, 32'd1);
      bus.in_valid = 1'b1;
      bus.op_a = a;
      bus.op_b = b;
      bus.sub = s;
      @(negedge clk);
      wait_done(tag);
      check({tag, "_sum"}, {16'd0, bus.sum}, {16'd0, e_sum});
      check({tag, "_cout"}, {31'd0, bus.cout}, {31'd0, e_c});
      check({tag, "_ovf"}, {31'd0, bus.ovf}, {31'd0, e_v});
      check({tag, "_busy"}, {31'd0, bus.in_ready}, 32'd0);
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      check({tag, "_idle"}, {30'd0, bus.in_ready, bus.out_valid}, 32'd2);
      check({tag, "_hold"}, {16'd0, bus.sum}, {16'd0, e_sum});
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.op_a = '0;
      bus.op_b = '0;
      bus.sub = 1'b0;
      bus.out_ready = 1'b0;
      #1;
      check("rst_out", {12'd0, bus.sum, bus.cout, bus.ovf, bus.out_valid, bus.in_ready}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      run_op("add_5555", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
      run_op("add_ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
      run_op("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
      run_op("sub_neg", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      run_op("sub_ovf", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);

      // Back-pressure: result must hold while requests are offered and ignored.
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.op_a = 16'h1111;
      bus.op_b = 16'h2222;
      bus.sub = 1'b0;
      @(negedge clk);
      wait_done("stall");
      bus.in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         bus.op_a = 16'(i * 16'h1357);
         bus.op_b = ~16'(i * 16'h0F0F);
         bus.sub = i[0];
         @(negedge clk);
         check("stall_state", {12'd0, bus.sum, bus.cout, bus.ovf, bus.out_valid, bus.in_ready},
               {12'd0, 16'h3333, 4'b0010});
      end
      bus.op_a = 16'h0001;
      bus.op_b = 16'h0002;
      bus.sub = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      check("stall_release", {12'd0, bus.sum, bus.cout, bus.ovf, bus.out_valid, bus.in_ready},
            {12'd0, 16'h3333, 4'b0001});
      @(negedge clk);
      check("stall_accept", {31'd0, bus.in_ready}, 32'd0);
      wait_done("stall_next");
      check("stall_next_sum", {16'd0, bus.sum}, 32'h0003);
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;

      // Abort mid-operation at idx=2.
      bus.in_valid = 1'b1;
      bus.op_a = 16'hAAAA;
      bus.op_b = 16'h5555;
      bus.sub = 1'b0;
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (2) @(negedge clk);
      check("abort_partial", {16'd0, bus.sum}, 32'h00FF);
      rst_n = 1'b0;
      #1;
      check("abort_out", {12'd0, bus.sum, bus.cout, bus.ovf, bus.out_valid, bus.in_ready}, 32'd0);
      repeat (2) @(negedge clk);
      check("abort_held", {12'd0, bus.sum, bus.cout, bus.ovf, bus.out_valid, bus.in_ready}, 32'd0);
      rst_n = 1'b1;
      run_op("post_rst", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/add16_seq_ctrl.md
ADD16_SEQ_CTRL -- requirements
Module: add16_seq_ctrl

Interface
REQ-001 The module SHALL have no parameters; operand width is fixed at 16 bits, processed as 4 nibbles.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  request present; op_a, op_b and sub are valid.
REQ-005 in_ready  output  1  block accepts a request this cycle.
REQ-006 op_a  input  16  operand A, unsigned or two's complement.
REQ-007 op_b  input  16  operand B, unsigned or two's complement.
REQ-008 sub  input  1  0 = A+B, 1 = A-B.
REQ-009 out_valid  output  1  result present on sum, cout and ovf.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 sum  output  16  result.
REQ-012 cout  output  1  carry out of bit 15; for subtract, 1 = no borrow.
REQ-013 ovf  output  1  two's-complement signed overflow.

Function
REQ-014 The FSM SHALL have three states: IDLE, RUN and DONE. Any unused encoding SHALL return to IDLE on the next edge.
REQ-015 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-016 IDLE: when in_valid && in_ready at an edge, the block SHALL:
- register op_a;
- register op_b, or ~op_b when sub=1;
- register sub into the carry flop;
- clear the nibble index to 0;
- enter RUN.
REQ-017 RUN: on each edge the block SHALL add nibble[idx] of A and (possibly inverted) B, plus the carry flop, through one 4-bit adder. It SHALL write the 4-bit result into sum[4*idx+3:4*idx], load the adder carry-out into the carry flop, and increment idx.
REQ-018 When the edge processes idx=3, the block SHALL instead:
- enter DONE;
- set cout to the final carry;
- set ovf = (A[15] == Bx[15]) && (sum[15] != A[15]), where Bx is the registered (possibly inverted) B.
REQ-019 Latency SHALL be exactly 4 edges from the accepting edge to out_valid=1, independent of operand values.
REQ-020 DONE: sum, cout and ovf SHALL remain stable until out_valid && out_ready. On that edge the block SHALL enter IDLE.
REQ-021 in_ready SHALL rise in the cycle after the output handshake; there SHALL be no accept in the same cycle as a result handshake.
REQ-022 in_valid, op_a, op_b and sub SHALL be ignored in RUN and DONE. out_ready SHALL be ignored outside DONE.
REQ-023 In IDLE, sum, cout and ovf SHALL hold the last result.
REQ-024 Intermediate nibbles of sum MAY change during RUN; they are defined only while out_valid=1.

Reset
REQ-025 While rst_n=0, the block SHALL asynchronously force all of the following, aborting any operation in progress:
- state=IDLE, idx=0, carry=0;
- sum=0, cout=0, ovf=0;
- out_valid=0, in_ready=0.
REQ-026 On the first edge after rst_n deasserts, in_ready SHALL be 1 (IDLE). No partial result from an aborted operation SHALL ever be presented.

Structure
REQ-027 The shared header SHALL hold the state encodings (IDLE, RUN, DONE), NIBBLES=4 and the last-index constant 3.
REQ-028 Exactly one sub-module SHALL be instantiated: the existing Adder4 (ports A, B, Cin, Z, Cout), used once and time-multiplexed across nibbles. No other adder logic is permitted.

Verification
REQ-029 The bench SHALL cover these directed scenarios:
- 0x1234 + 0x4321, sub=0 -> sum=0x5555, cout=0, ovf=0, out_valid exactly 4 edges after accept.
- 0xFFFF + 0x0001 -> sum=0x0000, cout=1, ovf=0 (carry ripples through all 4 nibbles).
- 0x7FFF + 0x0001 -> sum=0x8000, cout=0, ovf=1.
- Subtract cases:
  - 0x0005 - 0x0007 -> sum=0xFFFE, cout=0, ovf=0;
  - 0x8000 - 0x0001 -> sum=0x7FFF, cout=1, ovf=1.
- out_ready held 0 for 10 cycles in DONE, with in_valid=1 and operands toggling -> out_valid, sum, cout and ovf stable, in_ready=0. After out_ready=1 -> IDLE, and the next request is accepted one cycle later.
- rst_n pulsed low while idx=2 in RUN -> all outputs 0 immediately, IDLE after release. A following 0x00FF + 0x0001 -> sum=0x0100, cout=0, ovf=0.
